// File: rtl/aes_input_packer.sv
// -----------------------------------------------------------------------------
// aes_input_packer
//
// Write-side producer for the AES input packet FIFO. Collects a stream of
// WORD_W-bit host words into 128-bit blocks (first beat in the MSBs). The
// command sampled on the first beat tags each block as a key load, an encrypt
// or a decrypt. Each complete block is pushed into the FIFO once fifo_full is
// low. Blocks with the reserved command, and data blocks that arrive before
// any key has been loaded, are consumed in full and then dropped with a
// one-cycle error pulse.
//
// Ports
//   clk              clock
//   rst              asynchronous reset, active-high
//   host_valid       host word valid
//   host_ready       packer can accept a word (low while a block waits for the FIFO)
//   host_word        host data word, WORD_W bits
//   host_cmd         00 encrypt, 01 decrypt, 10 set key, 11 reserved (first beat only)
//   fifo_full        FIFO cannot accept a write
//   fifo_wr_en       FIFO write strobe
//   fifo_wr_data     128-bit packet data
//   fifo_wr_set_key  packet is a key load
//   fifo_wr_en_de    1 = encrypt, 0 = decrypt (0 for key packets)
//   busy             block partially collected or awaiting write
//   err_cmd          one-cycle pulse: reserved-command block dropped
//   err_nokey        one-cycle pulse: data block dropped, no key loaded yet
//   pkt_count        packets written to the FIFO, wraps modulo 2^CNT_W
//
// State table
//   state       | meaning
//   ST_COLLECT  | accepting host beats into the assembly register
//   ST_SEND     | complete block presented to the FIFO, waiting for !fifo_full
// -----------------------------------------------------------------------------
module aes_input_packer #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [WORD_W-1:0] host_word,
  input  logic [1:0]        host_cmd,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [127:0]      fifo_wr_data,
  output logic              fifo_wr_set_key,
  output logic              fifo_wr_en_de,
  output logic              busy,
  output logic              err_cmd,
  output logic              err_nokey,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int BEATS = 128 / WORD_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  localparam logic [1:0] CMD_ENC = 2'b00;
  localparam logic [1:0] CMD_KEY = 2'b10;
  localparam logic [1:0] CMD_RSV = 2'b11;

  if ((128 % WORD_W) != 0 || WORD_W < 8 || WORD_W > 64) begin : g_bad_word_w
    $error("aes_input_packer: WORD_W must be 8, 16, 32 or 64");
  end

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_SEND    = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [127:0]       data_q, data_d;
  logic [1:0]         cmd_q, cmd_d;
  logic               drop_q, drop_d;
  logic               key_loaded_q, key_loaded_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_cmd_q, err_cmd_d;
  logic               err_nokey_q, err_nokey_d;

  // Command and drop decision that apply to the current beat: taken live from
  // host_cmd on the first beat, from the latched copies afterwards.
  logic [1:0]         beat_cmd;
  logic               beat_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      idx_q        <= '0;
      data_q       <= '0;
      cmd_q        <= 2'b00;
      drop_q       <= 1'b0;
      key_loaded_q <= 1'b0;
      cnt_q        <= '0;
      err_cmd_q    <= 1'b0;
      err_nokey_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      cmd_q        <= cmd_d;
      drop_q       <= drop_d;
      key_loaded_q <= key_loaded_d;
      cnt_q        <= cnt_d;
      err_cmd_q    <= err_cmd_d;
      err_nokey_q  <= err_nokey_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    data_d          = data_q;
    cmd_d           = cmd_q;
    drop_d          = drop_q;
    key_loaded_d    = key_loaded_q;
    cnt_d           = cnt_q;
    err_cmd_d       = 1'b0;
    err_nokey_d     = 1'b0;
    host_ready      = 1'b0;
    fifo_wr_en      = 1'b0;
    fifo_wr_set_key = 1'b0;
    fifo_wr_en_de   = 1'b0;

    if (idx_q == '0) begin
      beat_cmd  = host_cmd;
      beat_drop = (host_cmd == CMD_RSV) || ((host_cmd != CMD_KEY) && !key_loaded_q);
    end else begin
      beat_cmd  = cmd_q;
      beat_drop = drop_q;
    end

    case (state_q)
      ST_COLLECT: begin
        host_ready = 1'b1;
        if (host_valid) begin
          cmd_d = beat_cmd;
          for (int b = 0; b < BEATS; b++) begin
            if (idx_q == IDX_W'(b)) begin
              data_d[127 - b*WORD_W -: WORD_W] = host_word;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            drop_d = 1'b0;
            if (beat_drop) begin
              // Whole block consumed; report why it never reaches the FIFO.
              err_cmd_d   = (beat_cmd == CMD_RSV);
              err_nokey_d = (beat_cmd != CMD_RSV);
            end else begin
              state_d = ST_SEND;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            drop_d = beat_drop;
          end
        end
      end

      ST_SEND: begin
        fifo_wr_en      = ~fifo_full;
        fifo_wr_set_key = (cmd_q == CMD_KEY);
        fifo_wr_en_de   = (cmd_q == CMD_ENC);
        if (!fifo_full) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_COLLECT;
          if (cmd_q == CMD_KEY) begin
            key_loaded_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  assign fifo_wr_data = data_q;
  assign busy         = (state_q == ST_SEND) || (idx_q != '0);
  assign err_cmd      = err_cmd_q;
  assign err_nokey    = err_nokey_q;
  assign pkt_count    = cnt_q;

endmodule

// File: tb/tb_aes_input_packer.sv
module tb_aes_input_packer;

  localparam int WORD_W = 32;
  localparam int BEATS  = 128 / WORD_W;

  logic              clk;
  logic              rst;
  logic              host_valid;
  logic [WORD_W-1:0] host_word;
  logic [1:0]        host_cmd;
  logic              fifo_full;
  logic              full_force;
  logic              rand_full;
  logic              rnd_bit;

  logic              host_ready, fifo_wr_en, fifo_wr_set_key, fifo_wr_en_de;
  logic              busy, err_cmd, err_nokey;
  logic [127:0]      fifo_wr_data;
  logic [15:0]       pkt_count;

  logic              host_ready_b, fifo_wr_en_b, fifo_wr_set_key_b, fifo_wr_en_de_b;
  logic              busy_b, err_cmd_b, err_nokey_b;
  logic [127:0]      fifo_wr_data_b;
  logic [1:0]        pkt_count_b;

  assign fifo_full = full_force | (rand_full & rnd_bit);

  aes_input_packer #(.WORD_W(WORD_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_word(host_word), .host_cmd(host_cmd), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_set_key(fifo_wr_set_key), .fifo_wr_en_de(fifo_wr_en_de),
    .busy(busy), .err_cmd(err_cmd), .err_nokey(err_nokey), .pkt_count(pkt_count)
  );

  aes_input_packer #(.WORD_W(WORD_W), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready_b),
    .host_word(host_word), .host_cmd(host_cmd), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en_b), .fifo_wr_data(fifo_wr_data_b),
    .fifo_wr_set_key(fifo_wr_set_key_b), .fifo_wr_en_de(fifo_wr_en_de_b),
    .busy(busy_b), .err_cmd(err_cmd_b), .err_nokey(err_nokey_b), .pkt_count(pkt_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 2) == 0);
  end

  int checks = 0;
  int passes = 0;

  // Monitor: everything the FIFO and the error outputs saw.
  logic [129:0] wr_q[$];
  time          wt_q[$];
  int           cnta_q[$];
  int           cntb_q[$];
  int           n_err_cmd, n_err_nokey, n_err_both, n_ab_diff;
  bit           prev_wr;

  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
    end else begin
      if (prev_wr) begin
        cnta_q.push_back(int'(pkt_count));
        cntb_q.push_back(int'(pkt_count_b));
      end
      prev_wr = fifo_wr_en;
      if (fifo_wr_en) begin
        wr_q.push_back({fifo_wr_data, fifo_wr_set_key, fifo_wr_en_de});
        wt_q.push_back($time);
      end
      if (err_cmd) n_err_cmd++;
      if (err_nokey) n_err_nokey++;
      if (err_cmd && err_nokey) n_err_both++;
      if ({host_ready_b, fifo_wr_en_b, fifo_wr_set_key_b, fifo_wr_en_de_b, busy_b,
           err_cmd_b, err_nokey_b, fifo_wr_data_b} !==
          {host_ready, fifo_wr_en, fifo_wr_set_key, fifo_wr_en_de, busy,
           err_cmd, err_nokey, fifo_wr_data}) n_ab_diff++;
    end
  end

  // Reference model: packet-level rules only.
  logic [129:0] exp_q[$];
  bit           model_key;
  int           model_cnt, exp_err_cmd, exp_err_nokey;

  task automatic model_packet(input logic [1:0] cmd, input logic [127:0] blk);
    if (cmd == 2'b11) exp_err_cmd++;
    else if (cmd != 2'b10 && !model_key) exp_err_nokey++;
    else begin
      exp_q.push_back({blk, cmd == 2'b10, cmd == 2'b00});
      model_cnt++;
      if (cmd == 2'b10) model_key = 1'b1;
    end
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_mon();
    wr_q.delete(); wt_q.delete(); cnta_q.delete(); cntb_q.delete();
    n_err_cmd = 0; n_err_nokey = 0; n_err_both = 0; n_ab_diff = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; host_valid = 1'b0; full_force = 1'b0; rand_full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    exp_q.delete(); model_key = 1'b0; model_cnt = 0; exp_err_cmd = 0; exp_err_nokey = 0;
  endtask

  // gaps: 0 none, 1 one idle cycle before each later beat, 2 random idles.
  // noise: 0 repeat cmd on later beats, 1 drive 10 on later beats, 2 random.
  task automatic drive_packet(input logic [1:0] cmd, input logic [127:0] blk,
                              input int nbeats, input int gaps, input int noise);
    for (int b = 0; b < nbeats; b++) begin
      int idle;
      idle = (gaps == 1 && b > 0) ? 1 : (gaps == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < idle; g++) begin
        host_valid = 1'b0; host_word = $urandom; host_cmd = 2'($urandom);
        @(posedge clk); #1;
      end
      host_valid = 1'b1;
      host_word  = blk[127 - b*WORD_W -: WORD_W];
      host_cmd   = (b == 0 || noise == 0) ? cmd : (noise == 1) ? 2'b10 : 2'($urandom);
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!host_ready && t < 100) begin t++; @(negedge clk); end
        if (!host_ready) begin
          checks++;
          $display("FAIL drive_ready_timeout: host_ready=%b want 1 within 100 cycles", host_ready);
        end
      end
      @(posedge clk); #1;
    end
    host_valid = 1'b0;
    host_word  = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 300) begin t++; @(negedge clk); end
    checks++;
    if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b want 0", busy); else passes++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (host_ready !== 1'b1) $display("FAIL rst_host_ready: got %b want 1", host_ready); else passes++;
    checks++; if (fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", fifo_wr_en); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
    checks++; if ({err_cmd, err_nokey} !== 2'b00) $display("FAIL rst_err: got %b want 00", {err_cmd, err_nokey}); else passes++;
    checks++; if (pkt_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", pkt_count); else passes++;
    checks++; if (fifo_wr_data !== 128'd0) $display("FAIL rst_data: got %h want 0", fifo_wr_data); else passes++;
    checks++; if ({fifo_wr_set_key, fifo_wr_en_de} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {fifo_wr_set_key, fifo_wr_en_de}); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_key_load();
    logic [127:0] k;
    k = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    drive_packet(2'b10, k, BEATS, 0, 0);
    @(negedge clk);
    checks++; if (fifo_wr_en !== 1'b1) $display("FAIL key_wr_en: got %b want 1", fifo_wr_en); else passes++;
    checks++; if (fifo_wr_data !== k) $display("FAIL key_data: got %h want %h", fifo_wr_data, k); else passes++;
    checks++; if ({fifo_wr_set_key, fifo_wr_en_de} !== 2'b10) $display("FAIL key_flags: got %b want 10", {fifo_wr_set_key, fifo_wr_en_de}); else passes++;
    checks++; if ({host_ready, busy} !== 2'b01) $display("FAIL key_send_ready_busy: got %b want 01", {host_ready, busy}); else passes++;
    @(negedge clk);
    checks++; if (fifo_wr_en !== 1'b0) $display("FAIL key_wr_en_after: got %b want 0", fifo_wr_en); else passes++;
    checks++; if (pkt_count !== 16'd1) $display("FAIL key_count: got %0d want 1", pkt_count); else passes++;
    checks++; if ({host_ready, busy} !== 2'b10) $display("FAIL key_idle_ready_busy: got %b want 10", {host_ready, busy}); else passes++;
    @(posedge clk); #1;
    checks++; if (wr_q.size() != 1) $display("FAIL key_write_count: got %0d want 1", wr_q.size()); else passes++;
  endtask

  task automatic test_no_key();
    logic [127:0] k, e;
    do_reset();
    drive_packet(2'b00, rand_blk(), BEATS, 0, 0);
    @(negedge clk);
    checks++; if ({err_nokey, err_cmd, fifo_wr_en} !== 3'b100) $display("FAIL nokey_pulse: got %b want 100", {err_nokey, err_cmd, fifo_wr_en}); else passes++;
    @(negedge clk);
    checks++; if (err_nokey !== 1'b0) $display("FAIL nokey_pulse_len: got %b want 0", err_nokey); else passes++;
    checks++; if (pkt_count !== 16'd0) $display("FAIL nokey_count: got %0d want 0", pkt_count); else passes++;
    @(posedge clk); #1;
    k = rand_blk(); e = rand_blk();
    drive_packet(2'b10, k, BEATS, 0, 0);
    drive_packet(2'b00, e, BEATS, 0, 0);
    wait_idle();
    checks++; if (wr_q.size() != 2) $display("FAIL nokey_writes: got %0d want 2", wr_q.size());
    else begin
      passes++;
      checks++; if (wr_q[0] !== {k, 2'b10}) $display("FAIL nokey_key_pkt: got %h want %h", wr_q[0], {k, 2'b10}); else passes++;
      checks++; if (wr_q[1] !== {e, 2'b01}) $display("FAIL nokey_enc_pkt: got %h want %h", wr_q[1], {e, 2'b01}); else passes++;
    end
    checks++; if (n_err_nokey != 1) $display("FAIL nokey_err_total: got %0d want 1", n_err_nokey); else passes++;
    checks++; if (pkt_count !== 16'd2) $display("FAIL nokey_count2: got %0d want 2", pkt_count); else passes++;
  endtask

  task automatic test_back_pressure();
    logic [127:0] d;
    int bad;
    clear_mon();
    d = rand_blk();
    bad = 0;
    full_force = 1'b1;
    drive_packet(2'b00, d, BEATS, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ({host_ready, fifo_wr_en, fifo_wr_set_key, fifo_wr_en_de, fifo_wr_data} !== {4'b0001, d}) bad++;
    end
    checks++; if (bad != 0) $display("FAIL bp_hold: got %0d bad stall cycles want 0", bad); else passes++;
    @(posedge clk); #1;
    full_force = 1'b0;
    @(negedge clk);
    checks++; if ({fifo_wr_en, fifo_wr_data} !== {1'b1, d}) $display("FAIL bp_release: got %b %h want 1 %h", fifo_wr_en, fifo_wr_data, d); else passes++;
    @(negedge clk);
    checks++; if ({fifo_wr_en, host_ready} !== 2'b01) $display("FAIL bp_after: got %b want 01", {fifo_wr_en, host_ready}); else passes++;
    @(posedge clk); #1;
    checks++; if (wr_q.size() != 1) $display("FAIL bp_writes: got %0d want 1", wr_q.size()); else passes++;
  endtask

  task automatic test_reserved_gaps();
    logic [127:0] k;
    logic [15:0]  c0;
    clear_mon();
    c0 = pkt_count;
    drive_packet(2'b11, rand_blk(), BEATS, 1, 1);
    @(negedge clk);
    checks++; if ({err_cmd, err_nokey, fifo_wr_en, busy} !== 4'b1000) $display("FAIL rsv_pulse: got %b want 1000", {err_cmd, err_nokey, fifo_wr_en, busy}); else passes++;
    @(posedge clk); #1;
    k = rand_blk();
    drive_packet(2'b10, k, BEATS, 0, 0);
    wait_idle();
    checks++; if (n_err_cmd != 1) $display("FAIL rsv_err_total: got %0d want 1", n_err_cmd); else passes++;
    checks++; if (wr_q.size() != 1 || wr_q[0] !== {k, 2'b10}) $display("FAIL rsv_next_pkt: got %0d writes, first %h want 1, %h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 130'd0, {k, 2'b10}); else passes++;
    checks++; if (pkt_count !== c0 + 16'd1) $display("FAIL rsv_count: got %0d want %0d", pkt_count, c0 + 16'd1); else passes++;
  endtask

  task automatic test_reset_mid();
    drive_packet(2'b10, rand_blk(), 2, 0, 0);
    checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, fifo_wr_en, host_ready, pkt_count} !== {3'b001, 16'd0}) $display("FAIL mid_reset: got %b %0d want 001 0", {busy, fifo_wr_en, host_ready}, pkt_count); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    drive_packet(2'b01, rand_blk(), BEATS, 0, 0);
    @(negedge clk);
    checks++; if (err_nokey !== 1'b1) $display("FAIL mid_nokey: got %b want 1", err_nokey); else passes++;
    wait_idle();
    checks++; if (wr_q.size() != 0) $display("FAIL mid_writes: got %0d want 0", wr_q.size()); else passes++;
  endtask

  task automatic test_wrap_back_to_back();
    int exp_b[5];
    exp_b = '{1, 2, 3, 0, 1};
    do_reset();
    for (int p = 0; p < 5; p++) drive_packet(2'b10, rand_blk(), BEATS, 0, 0);
    wait_idle();
    checks++;
    if (cntb_q.size() != 5 || cnta_q.size() != 5 || wt_q.size() != 5) $display("FAIL wrap_writes: got %0d want 5", cntb_q.size());
    else begin
      passes++;
      for (int p = 0; p < 5; p++) begin
        checks++; if (cntb_q[p] != exp_b[p]) $display("FAIL wrap_count%0d: got %0d want %0d", p, cntb_q[p], exp_b[p]); else passes++;
        checks++; if (cnta_q[p] != p + 1) $display("FAIL wide_count%0d: got %0d want %0d", p, cnta_q[p], p + 1); else passes++;
      end
      for (int p = 1; p < 5; p++) begin
        checks++; if (wt_q[p] - wt_q[p-1] != 50) $display("FAIL throughput%0d: got %0t want 50 between writes", p, wt_q[p] - wt_q[p-1]); else passes++;
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [1:0]   cmd;
    logic [127:0] blk;
    do_reset();
    rand_full = 1'b1;
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 3) ? 2'b10 : (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : 2'b11;
      blk = rand_blk();
      model_packet(cmd, blk);
      drive_packet(cmd, blk, BEATS, 2, 2);
    end
    wait_idle();
    rand_full = 1'b0;
    checks++;
    if (wr_q.size() != exp_q.size()) $display("FAIL rnd_writes: got %0d want %0d", wr_q.size(), exp_q.size());
    else begin
      passes++;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL rnd_pkt%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passes++;
      end
    end
    checks++; if (n_err_cmd != exp_err_cmd) $display("FAIL rnd_err_cmd: got %0d want %0d", n_err_cmd, exp_err_cmd); else passes++;
    checks++; if (n_err_nokey != exp_err_nokey) $display("FAIL rnd_err_nokey: got %0d want %0d", n_err_nokey, exp_err_nokey); else passes++;
    checks++; if (n_err_both != 0) $display("FAIL rnd_err_both: got %0d want 0", n_err_both); else passes++;
    checks++; if (pkt_count !== 16'(model_cnt)) $display("FAIL rnd_count: got %0d want %0d", pkt_count, model_cnt); else passes++;
    checks++; if (pkt_count_b !== 2'(model_cnt)) $display("FAIL rnd_count_wrap: got %0d want %0d", pkt_count_b, model_cnt % 4); else passes++;
    checks++; if (n_ab_diff != 0) $display("FAIL rnd_width_indep: got %0d differing cycles want 0", n_ab_diff); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    host_valid = 1'b0; host_word = '0; host_cmd = 2'b00;
    full_force = 1'b0; rand_full = 1'b0; rnd_bit = 1'b0;
    clear_mon();
    test_reset();
    test_key_load();
    test_no_key();
    test_back_pressure();
    test_reserved_gaps();
    test_reset_mid();
    test_wrap_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aes_input_packer.md
Name: aes_input_packer

Overview:
- Write-side producer for the AES input packet FIFO; the AES controller is the reader that pops these packets.
- Accepts a narrow host word stream (valid/ready) and assembles 128-bit blocks, each tagged as key-load, encrypt or decrypt.
- Pushes each assembled packet (data, set_key, en_de) into the FIFO, honouring back-pressure from fifo_full.
- Enforces packet hygiene: reserved commands and data packets sent before any key are dropped and flagged.

Parameters:
WORD_W, 32, host word width; legal values 8, 16, 32, 64 (must divide 128)
CNT_W, 16, width of the written-packet counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
host_valid  in  1  host word valid
host_ready  out  1  packer can accept a word
host_word  in  WORD_W  host data word
host_cmd  in  2  sampled on first beat only: 00 encrypt, 01 decrypt, 10 set key, 11 reserved
fifo_full  in  1  FIFO cannot accept a write
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  128  packet data
fifo_wr_set_key  out  1  packet is a key load
fifo_wr_en_de  out  1  1 = encrypt, 0 = decrypt; 0 for key packets
busy  out  1  packet partially collected or awaiting write
err_cmd  out  1  one-cycle pulse: reserved command packet dropped
err_nokey  out  1  one-cycle pulse: data packet dropped because no key has been loaded
pkt_count  out  CNT_W  packets written to the FIFO; wraps modulo 2^CNT_W

Behaviour:
- Constants: BEATS = 128/WORD_W; beat index width = clog2(BEATS), minimum 1.
- Beat transfer: a beat transfers when host_valid && host_ready.
- Reset (async, rst=1) values:
  - state = COLLECT, beat index = 0, assembly register = 0.
  - cmd_latched = 00, drop = 0, key_loaded = 0, pkt_count = 0.
  - Output values during reset: host_ready = 1, fifo_wr_en = 0, err_cmd = 0, err_nokey = 0, busy = 0.
  - fifo_wr_data, fifo_wr_set_key and fifo_wr_en_de are 0.
- Reset mid-packet: the partial block is lost and no write is issued.
- Assembly order is MSB first: beat k lands in bits [127-k*WORD_W -: WORD_W].
- FSM with two states, COLLECT and SEND:
  - COLLECT:
    - host_ready = 1.
    - On beat 0: latch host_cmd. Set drop = 1 if cmd = 11, or if cmd is 00/01 and key_loaded = 0. The beat is still consumed.
    - Each beat: store the word and increment the beat index.
    - On beat BEATS-1 with drop = 0: go to SEND and reset the index to 0.
    - On beat BEATS-1 with drop = 1: stay in COLLECT, reset the index, clear drop, and pulse err_cmd or err_nokey in the next cycle.
  - SEND:
    - host_ready = 0.
    - fifo_wr_en = ~fifo_full (combinational from fifo_full).
    - fifo_wr_set_key = (cmd_latched == 10); fifo_wr_en_de = (cmd_latched == 00).
    - On the write cycle: increment pkt_count, set key_loaded if set_key, return to COLLECT.
    - While fifo_full = 1, data and flags are held stable indefinitely.
- Outputs outside SEND: fifo_wr_set_key and fifo_wr_en_de are 0; fifo_wr_data holds the last assembled value.
- Latency: last beat accepted at edge N gives fifo_wr_en high in the cycle after N if fifo_full = 0.
- Throughput: one packet per BEATS+1 cycles.
- host_cmd on beats 1..BEATS-1 is ignored.
- host_word is ignored when host_valid = 0, or when in SEND.
- busy = (state == SEND) || (beat index != 0).
- key_loaded is never cleared except by rst; a later set-key packet re-keys without error.
- pkt_count counts writes only; dropped packets are not counted. It wraps from 2^CNT_W-1 to 0.
- err_cmd and err_nokey are registered, never simultaneous, and at most one pulse per packet.

Test Plan:
- Key load: WORD_W=32, cmd 10, words 2B7E1516, 28AED2A6, ABF71588, 09CF4F3C on back-to-back cycles, fifo_full=0. Expect exactly one fifo_wr_en one cycle after the last beat, with data 2B7E151628AED2A6ABF7158809CF4F3C, set_key=1, en_de=0, pkt_count=1.
- No key yet: after reset, cmd 00 with 4 words. Expect no fifo_wr_en, err_nokey pulse one cycle after beat 4, pkt_count=0. Then a key packet followed by an encrypt packet gives two writes, the second with set_key=0 and en_de=1.
- Back-pressure: fifo_full=1 for 5 cycles while in SEND. Expect host_ready=0, fifo_wr_en=0, data stable; after fifo_full drops, exactly one write, then host_ready=1.
- Reserved cmd and host gaps: cmd 11, with host_valid toggled 1,0,1,0,... across beats. All 4 beats are consumed, then err_cmd pulses once with no write. cmd on beats 2-4 changed to 10 has no effect.
- Reset mid-packet: assert rst after 2 beats of a key packet. Expect busy=0 and no write. key_loaded cleared, so a following decrypt packet raises err_nokey.
- Wrap: CNT_W=2, five key packets. Expect pkt_count sequence 1, 2, 3, 0, 1.
